// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle LEGv8 control FSM.
// Optional unconditional-branch decode is enabled by defining MCCTRL_B_EN.
package multicycle_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    LDWB    = 4'd4,
    MEMWR   = 4'd5,
    RTYPE   = 4'd6,
    RWB     = 4'd7,
    CBZ     = 4'd8,
    ILLEGAL = 4'd9,
    BRANCH  = 4'd10
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [7:0] OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0] OP_B_PFX   = 6'b000101;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_cnt.sv
// Memory wait-state counter with a sticky timeout flag.
module mem_wait_cnt #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    // req only drops on completion, so !req covers leaving a memory state
    if (!req_i || ready_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(MAX_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (req_i && !ready_i && (cnt_q == CNT_W'(MAX_WAIT))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM sharing one memory port between fetch and data.
// Define MCCTRL_B_EN to decode unconditional B into the BRANCH state.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W     = 11,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] Op,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCSrc,
  output logic            Reg2Loc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic            illegal_op,
  output logic            mem_timeout,
  output state_t          state_dbg_o
);

  // Handshake: mem_req rises with an access and stays high until the cycle
  // mem_ready=1; that cycle completes the access and the FSM moves on.

  state_t state_q, state_d;

  logic is_ld, is_st, is_r, is_cbz;
  assign is_ld  = (Op == OP_LDUR);
  assign is_st  = (Op == OP_STUR);
  assign is_r   = is_rtype(Op);
  assign is_cbz = (Op[10:3] == OP_CBZ_PFX);
`ifdef MCCTRL_B_EN
  logic is_b;
  assign is_b = (Op[10:5] == OP_B_PFX);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 1'b0;
    Reg2Loc     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    illegal_op  = 1'b0;
    // Outputs are gated by reset so an async assert drops mem_req at once
    if (reset_n) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_BR;
          Reg2Loc = is_st | is_cbz;
          if (is_ld || is_st)  state_d = MEMADR;
          else if (is_r)       state_d = RTYPE;
          else if (is_cbz)     state_d = CBZ;
`ifdef MCCTRL_B_EN
          else if (is_b)       state_d = BRANCH;
`endif
          else                 state_d = ILLEGAL;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = is_ld ? MEMRD : MEMWR;
        end
        MEMRD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (mem_ready) state_d = LDWB;
        end
        LDWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          state_d  = FETCH;
        end
        MEMWR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
          if (mem_ready) state_d = FETCH;
        end
        RTYPE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
          state_d = RWB;
        end
        RWB: begin
          RegWrite = 1'b1;
          state_d  = FETCH;
        end
        CBZ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_PASSB;
          Reg2Loc     = 1'b1;
          PCWriteCond = 1'b1;
          PCSrc       = 1'b1;
          state_d     = FETCH;
        end
        ILLEGAL: begin
          illegal_op = 1'b1;
          state_d    = FETCH;
        end
`ifdef MCCTRL_B_EN
        BRANCH: begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
          state_d = FETCH;
        end
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  mem_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (mem_req),
    .ready_i   (mem_ready),
    .timeout_o (mem_timeout)
  );

  assign state_dbg_o = state_q;

endmodule
